// File: rtl/phase_shifter_ctrl.sv
// phase_shifter_ctrl
//
// Sequencing controller for the 1.28 GHz phase-shifter macro, running in the 40 MHz
// slow-control domain. It brings up the triple-redundant DLL (cap reset + force-down,
// then acquire), declares lock from the voted late flags, and walks the 8-bit phase
// select toward a requested value one LSB per step with a settle gap, so the macro's
// output clocks never glitch.
//
// Ports
//   clk40, rstn                   control clock, async active-low reset
//   enable                        level: 1 runs the DLL, 0 returns to IDLE
//   relock                        pulse: restart bring-up from any non-IDLE state
//   cpCurrentCfg[3:0]             charge-pump current, latched when leaving IDLE
//   dllLateA/B/C                  async late flags from the three DLL replicas
//   phaseReq[7:0], phaseReqValid  phase request {coarse[4:0], fine[2:0]}
//   phaseReqReady                 request accepted when valid && ready
//   s[7:0]                        phase select to the macro
//   dllEnableA/B/C, dllCapResetA/B/C, dllForceDown, dllChargePumpCurrent[3:0]
//                                 DLL configuration pins
//   dllLocked                     lock status
//   lockFailCnt[3:0]              acquire timeouts that forced a cap reset, saturating

module phase_shifter_ctrl #(
  parameter int unsigned CAP_RESET_CYCLES = 16,
  parameter int unsigned LOCK_WINDOW      = 64,
  parameter int unsigned LOCK_TOGGLES     = 4,
  parameter int unsigned MAX_TRIES        = 4,
  parameter int unsigned SETTLE_CYCLES    = 4
) (
  input  logic       clk40,
  input  logic       rstn,
  input  logic       enable,
  input  logic       relock,
  input  logic [3:0] cpCurrentCfg,
  input  logic       dllLateA,
  input  logic       dllLateB,
  input  logic       dllLateC,
  input  logic [7:0] phaseReq,
  input  logic       phaseReqValid,
  output logic       phaseReqReady,
  output logic [7:0] s,
  output logic       dllEnableA,
  output logic       dllEnableB,
  output logic       dllEnableC,
  output logic       dllCapResetA,
  output logic       dllCapResetB,
  output logic       dllCapResetC,
  output logic       dllForceDown,
  output logic [3:0] dllChargePumpCurrent,
  output logic       dllLocked,
  output logic [3:0] lockFailCnt
);

  localparam int unsigned CapW = $clog2(CAP_RESET_CYCLES + 1);
  localparam int unsigned WinW = $clog2(LOCK_WINDOW + 1);
  localparam int unsigned TogW = $clog2(LOCK_TOGGLES + 1);
  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CapW-1:0] CapLast = CapW'(CAP_RESET_CYCLES - 1);
  localparam logic [WinW-1:0] WinLast = WinW'(LOCK_WINDOW - 1);
  localparam logic [TogW-1:0] TogLast = TogW'(LOCK_TOGGLES - 1);
  localparam logic [TryW-1:0] TryLast = TryW'(MAX_TRIES - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapRst,
    StAcquire,
    StLocked,
    StStep,
    StSettle
  } state_e;

  state_e          state_q;
  logic [2:0]      meta_q, sync_q;
  logic            late, late_d_q, toggle;
  logic [CapW-1:0] cap_cnt_q;
  logic [WinW-1:0] win_cnt_q, quiet_cnt_q;
  logic [TogW-1:0] tog_cnt_q;
  logic [TryW-1:0] try_cnt_q;
  logic [SetW-1:0] settle_cnt_q;
  logic [7:0]      target_q, s_q;
  logic            dll_en_q, cap_reset_q, force_down_q, locked_q, ready_q;
  logic [3:0]      cp_current_q, fail_cnt_q;

  logic            monitoring, lock_lost, acq_lock, acq_fail, relock_hit, handshake;

  // Per-replica 2-flop synchronizers, then a 2-of-3 vote.
  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      meta_q   <= '0;
      sync_q   <= '0;
      late_d_q <= 1'b0;
    end else begin
      meta_q   <= {dllLateC, dllLateB, dllLateA};
      sync_q   <= meta_q;
      late_d_q <= late;
    end
  end

  assign late   = (sync_q[0] & sync_q[1]) | (sync_q[0] & sync_q[2]) | (sync_q[1] & sync_q[2]);
  assign toggle = late ^ late_d_q;

  // Lock monitor spans LOCKED, STEP and SETTLE: LOCK_WINDOW consecutive quiet cycles lose lock.
  assign monitoring = (state_q == StLocked) || (state_q == StStep) || (state_q == StSettle);
  assign lock_lost  = monitoring && !toggle && (quiet_cnt_q == WinLast);
  assign acq_lock   = (state_q == StAcquire) && toggle && (tog_cnt_q == TogLast);
  assign acq_fail   = (state_q == StAcquire) && !acq_lock && (win_cnt_q == WinLast) &&
                      (try_cnt_q == TryLast);
  assign relock_hit = relock && (state_q != StIdle);
  assign handshake  = (state_q == StLocked) && phaseReqValid && ready_q;

  always_ff @(posedge clk40 or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cap_cnt_q    <= '0;
      win_cnt_q    <= '0;
      quiet_cnt_q  <= '0;
      tog_cnt_q    <= '0;
      try_cnt_q    <= '0;
      settle_cnt_q <= '0;
      target_q     <= '0;
      s_q          <= '0;
      dll_en_q     <= 1'b0;
      cap_reset_q  <= 1'b1;
      force_down_q <= 1'b0;
      locked_q     <= 1'b0;
      ready_q      <= 1'b0;
      cp_current_q <= '0;
      fail_cnt_q   <= '0;
    end else if (!enable) begin
      // s is deliberately left alone so the macro keeps its last phase.
      state_q      <= StIdle;
      dll_en_q     <= 1'b0;
      cap_reset_q  <= 1'b1;
      force_down_q <= 1'b0;
      locked_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else if ((state_q == StIdle) || relock_hit || acq_fail || lock_lost) begin
      if (state_q == StIdle) begin
        cp_current_q <= cpCurrentCfg;
      end
      if (acq_fail && !relock_hit && fail_cnt_q != 4'hf) begin
        fail_cnt_q <= fail_cnt_q + 4'd1;
      end
      state_q      <= StCapRst;
      cap_cnt_q    <= '0;
      dll_en_q     <= 1'b1;
      cap_reset_q  <= 1'b1;
      force_down_q <= 1'b1;
      locked_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      if (monitoring) begin
        quiet_cnt_q <= toggle ? '0 : quiet_cnt_q + 1'b1;
      end
      unique case (state_q)
        StCapRst: begin
          if (cap_cnt_q == CapLast) begin
            state_q      <= StAcquire;
            cap_reset_q  <= 1'b0;
            force_down_q <= 1'b0;
            win_cnt_q    <= '0;
            tog_cnt_q    <= '0;
            try_cnt_q    <= '0;
          end else begin
            cap_cnt_q <= cap_cnt_q + 1'b1;
          end
        end
        StAcquire: begin
          if (acq_lock) begin
            state_q     <= StLocked;
            locked_q    <= 1'b1;
            ready_q     <= 1'b1;
            quiet_cnt_q <= '0;
          end else if (win_cnt_q == WinLast) begin
            // Short window: start a fresh one (acq_fail handled the last try above).
            win_cnt_q <= '0;
            tog_cnt_q <= '0;
            try_cnt_q <= try_cnt_q + 1'b1;
          end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
            if (toggle) begin
              tog_cnt_q <= tog_cnt_q + 1'b1;
            end
          end
        end
        StLocked: begin
          if (handshake) begin
            target_q <= phaseReq;
            if (phaseReq != s_q) begin
              state_q <= StStep;
              ready_q <= 1'b0;
            end
          end
        end
        StStep: begin
          if (target_q > s_q) begin
            s_q <= s_q + 8'd1;
          end else if (target_q < s_q) begin
            s_q <= s_q - 8'd1;
          end
          state_q      <= StSettle;
          settle_cnt_q <= '0;
        end
        StSettle: begin
          if (settle_cnt_q == SetLast) begin
            if (s_q != target_q) begin
              state_q <= StStep;
            end else begin
              state_q <= StLocked;
              ready_q <= 1'b1;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign phaseReqReady        = ready_q;
  assign s                    = s_q;
  assign dllEnableA           = dll_en_q;
  assign dllEnableB           = dll_en_q;
  assign dllEnableC           = dll_en_q;
  assign dllCapResetA         = cap_reset_q;
  assign dllCapResetB         = cap_reset_q;
  assign dllCapResetC         = cap_reset_q;
  assign dllForceDown         = force_down_q;
  assign dllChargePumpCurrent = cp_current_q;
  assign dllLocked            = locked_q;
  assign lockFailCnt          = fail_cnt_q;

endmodule

// File: tb/tb_phase_shifter_ctrl.sv
// Self-checking bench for phase_shifter_ctrl. Expected values come from the
// behavioural rules: bring-up durations, lock latency, and phase trajectories
// computed arithmetically from start value, target and step period.

module tb_phase_shifter_ctrl;

  localparam int unsigned CapCycles  = 16;
  localparam int unsigned Window     = 64;
  localparam int unsigned Toggles    = 4;
  localparam int unsigned Tries      = 4;
  localparam int unsigned Settle     = 4;
  localparam int          StepPeriod = Settle + 1;

  logic       clk40 = 1'b0;
  logic       rstn = 1'b1;
  logic       enable = 1'b0;
  logic       relock = 1'b0;
  logic [3:0] cfg = 4'h0;
  logic       late_a = 1'b0, late_b = 1'b0, late_c = 1'b0;
  logic [7:0] phase_req = 8'h00;
  logic       req_valid = 1'b0;

  logic       ready;
  logic [7:0] s;
  logic       en_a, en_b, en_c, cr_a, cr_b, cr_c, force_down, locked;
  logic [3:0] cp_cur, fail_cnt;

  int compared = 0;
  int mismatched = 0;
  int mode = 0;   // 0 all toggle, 1 B stuck high, 2 A+B stuck high, 3 flags frozen
  int ph = 0;
  logic src = 1'b0;
  int s_exp = 0;
  int fail_exp = 0;
  logic [3:0] cfg_exp;

  phase_shifter_ctrl #(
    .CAP_RESET_CYCLES(CapCycles),
    .LOCK_WINDOW     (Window),
    .LOCK_TOGGLES    (Toggles),
    .MAX_TRIES       (Tries),
    .SETTLE_CYCLES   (Settle)
  ) dut (
    .clk40               (clk40),
    .rstn                (rstn),
    .enable              (enable),
    .relock              (relock),
    .cpCurrentCfg        (cfg),
    .dllLateA            (late_a),
    .dllLateB            (late_b),
    .dllLateC            (late_c),
    .phaseReq            (phase_req),
    .phaseReqValid       (req_valid),
    .phaseReqReady       (ready),
    .s                   (s),
    .dllEnableA          (en_a),
    .dllEnableB          (en_b),
    .dllEnableC          (en_c),
    .dllCapResetA        (cr_a),
    .dllCapResetB        (cr_b),
    .dllCapResetC        (cr_c),
    .dllForceDown        (force_down),
    .dllChargePumpCurrent(cp_cur),
    .dllLocked           (locked),
    .lockFailCnt         (fail_cnt)
  );

  always #5 clk40 = ~clk40;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; late flags change 1 time unit after the edge, toggling every 2 cycles.
  task automatic tick();
    @(posedge clk40);
    #1;
    ph++;
    if (ph % 2 == 0) src = ~src;
    case (mode)
      0: begin late_a = src;  late_b = src;  late_c = src; end
      1: begin late_a = src;  late_b = 1'b1; late_c = src; end
      2: begin late_a = 1'b1; late_b = 1'b1; late_c = src; end
      default: ;
    endcase
  endtask

  task automatic wait_lock(input string tag, input int bound);
    int n = 0;
    while (locked !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(locked), 32'd1);
  endtask

  task automatic check_group(input string tag, input logic [2:0] obs, input logic v);
    check(tag, 32'(obs), 32'({v, v, v}));
  endtask

  // Handshake one request and follow the whole stepping trajectory.
  task automatic request(input logic [7:0] t);
    int s0 = s_exp;
    int n = (int'(t) > s0) ? int'(t) - s0 : s0 - int'(t);
    int dir = (int'(t) > s0) ? 1 : -1;
    int e;
    check("req_ready_before", 32'(ready), 32'd1);
    phase_req = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (n == 0) begin
      for (int i = 0; i < 2 * StepPeriod; i++) begin
        check("req_equal_s", 32'(s), 32'(s0));
        check("req_equal_ready", 32'(ready), 32'd1);
        tick();
      end
    end else begin
      check("req_capture_ready", 32'(ready), 32'd0);
      check("req_capture_s", 32'(s), 32'(s0));
      for (int k = 1; k <= n * StepPeriod; k++) begin
        tick();
        e = s0 + dir * ((k - 1) / StepPeriod + 1);
        check("step_s", 32'(s), 32'(e));
        check("step_ready", 32'(ready), 32'(k == n * StepPeriod));
        check("step_locked", 32'(locked), 32'd1);
      end
    end
    s_exp = int'(t);
  endtask

  initial begin
    int n;
    int s0;
    int dir;
    int e;
    logic [7:0] t;

    // Reset values.
    #2 rstn = 1'b0;
    #1;
    check("rst_s", 32'(s), 32'd0);
    check_group("rst_enables", {en_a, en_b, en_c}, 1'b0);
    check_group("rst_capreset", {cr_a, cr_b, cr_c}, 1'b1);
    check("rst_forcedown", 32'(force_down), 32'd0);
    check("rst_cp", 32'(cp_cur), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_failcnt", 32'(fail_cnt), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check_group("idle_enables", {en_a, en_b, en_c}, 1'b0);

    // Bring-up.
    cfg_exp = 4'($urandom_range(0, 15));
    cfg = cfg_exp;
    enable = 1'b1;
    tick();
    cfg = ~cfg_exp;
    check("bringup_cp", 32'(cp_cur), 32'(cfg_exp));
    check_group("bringup_enables", {en_a, en_b, en_c}, 1'b1);
    check_group("bringup_capreset", {cr_a, cr_b, cr_c}, 1'b1);
    n = 0;
    while (force_down === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("bringup_caprst_len", 32'(n), 32'(CapCycles));
    check_group("acquire_capreset", {cr_a, cr_b, cr_c}, 1'b0);
    n = 0;
    while (locked !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("bringup_lock_latency_ok", 32'(n >= 2 * Toggles - 1 && n <= 2 * Toggles), 32'd1);
    check("bringup_ready", 32'(ready), 32'd1);
    check("bringup_cp_held", 32'(cp_cur), 32'(cfg_exp));

    // Stepping up, down, equal, and the top boundary.
    request(8'h05);
    request(8'h02);
    request(8'h02);
    request(8'hFE);
    request(8'hFF);
    request(8'hFF);
    for (int i = 0; i < 3; i++) begin
      request(8'($urandom_range(0, 255)));
    end

    // Relock during SETTLE.
    s0 = s_exp;
    dir = (s0 < 128) ? 1 : -1;
    t = 8'(s0 + 3 * dir);
    phase_req = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    check("relock_forcedown", 32'(force_down), 32'd1);
    check_group("relock_capreset", {cr_a, cr_b, cr_c}, 1'b1);
    check("relock_locked", 32'(locked), 32'd0);
    check("relock_ready", 32'(ready), 32'd0);
    check("relock_s", 32'(s), 32'(s0 + dir));
    s_exp = s0 + dir;
    wait_lock("relock_relocked", 200);

    // Voting: B stuck high still locks.
    mode = 1;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    wait_lock("vote_b_stuck_lock", 300);

    // A and B stuck high: no toggles, acquire times out after all tries.
    mode = 2;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    n = 0;
    while (force_down === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("stuck_caprst_len", 32'(n), 32'(CapCycles));
    n = 0;
    while (force_down === 1'b0 && n < 1000) begin
      n++;
      tick();
    end
    check("stuck_acquire_len", 32'(n), 32'(Tries * Window));
    fail_exp++;
    check("stuck_failcnt", 32'(fail_cnt), 32'(fail_exp));
    check("stuck_locked", 32'(locked), 32'd0);
    mode = 0;
    wait_lock("stuck_recover_lock", 300);
    check("stuck_failcnt_kept", 32'(fail_cnt), 32'(fail_exp));

    // Lock loss mid-stepping: flags frozen right after the handshake.
    s0 = s_exp;
    dir = (s0 <= 200) ? 1 : -1;
    t = 8'(s0 + 20 * dir);
    phase_req = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    mode = 3;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      n = k;
      if (locked !== 1'b1) break;
    end
    check("loss_timing_ok", 32'(n >= int'(Window) && n <= int'(Window) + 4), 32'd1);
    e = (n - 2) / StepPeriod + 1;
    if (e > 20) e = 20;
    e = s0 + dir * e;
    check("loss_s", 32'(s), 32'(e));
    check("loss_forcedown", 32'(force_down), 32'd1);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_failcnt", 32'(fail_cnt), 32'(fail_exp));
    mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("loss_s_frozen", 32'(s), 32'(e));
    end
    s_exp = e;
    wait_lock("loss_relock", 300);

    // Drop enable.
    enable = 1'b0;
    tick();
    check_group("disable_enables", {en_a, en_b, en_c}, 1'b0);
    check_group("disable_capreset", {cr_a, cr_b, cr_c}, 1'b1);
    check("disable_forcedown", 32'(force_down), 32'd0);
    check("disable_locked", 32'(locked), 32'd0);
    check("disable_ready", 32'(ready), 32'd0);
    check("disable_s", 32'(s), 32'(s_exp));

    // Re-enable with a new charge-pump setting, then reset mid-step.
    cfg_exp = 4'($urandom_range(0, 15));
    cfg = cfg_exp;
    enable = 1'b1;
    tick();
    check("reenable_cp", 32'(cp_cur), 32'(cfg_exp));
    wait_lock("reenable_lock", 100);
    s0 = s_exp;
    dir = (s0 < 128) ? 1 : -1;
    phase_req = 8'(s0 + 10 * dir);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("prereset_s", 32'(s), 32'(s0 + 2 * dir));
    @(posedge clk40);
    #3;
    rstn = 1'b0;
    #1;
    check("areset_s", 32'(s), 32'd0);
    check_group("areset_enables", {en_a, en_b, en_c}, 1'b0);
    check_group("areset_capreset", {cr_a, cr_b, cr_c}, 1'b1);
    check("areset_locked", 32'(locked), 32'd0);
    check("areset_failcnt", 32'(fail_cnt), 32'd0);
    check("areset_cp", 32'(cp_cur), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_reset_s", 32'(s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
